// File: rtl/pll_rst_ctrl.sv
// PLL reset and lock sequencer: holds the PLL in reset, qualifies extlock and
// releases the system reset after a stable lock, retrying a bounded number of times.
module pll_rst_ctrl #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 240,
    parameter int LOCK_TIMEOUT_CYC = 4800,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_extlock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    localparam int HW = $clog2(RST_HOLD_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [SW-1:0] STABLE_ONE  = SW'(1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic            lock_s;
    logic [HW-1:0]   hold_cnt;
    logic [SW-1:0]   stable_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [3:0]      attempt;
    logic            lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pll_extlock;
            sync2 <= sync1;
        end
    end

    assign lock_s = sync2;

    // Outputs are decoded from the current state, so they follow a transition by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            hold_cnt   <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            attempt    <= '0;
            lost       <= 1'b0;
            pll_reset  <= 1'b1;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            lock_lost  <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            pll_reset <= (state == ST_RST) || (state == ST_FAIL);
            sys_rst_n <= (state == ST_RUN);
            locked    <= (state == ST_RUN);
            fail      <= (state == ST_FAIL);
            lock_lost <= lost;
            retry_cnt <= attempt;

            case (state)
                ST_RST: begin
                    if (hold_cnt >= HOLD_LAST) begin
                        state      <= ST_WAIT_LOCK;
                        hold_cnt   <= '0;
                        tmo_cnt    <= '0;
                        stable_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (tmo_cnt >= TMO_LAST) begin
                        hold_cnt <= '0;
                        if (attempt < RETRY_MAX) begin
                            attempt <= attempt + 1'b1;
                            state   <= ST_RST;
                        end else begin
                            state <= ST_FAIL;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (lock_s) begin
                            state      <= ST_STABLE;
                            stable_cnt <= STABLE_ONE;
                        end
                    end
                end

                // A completed stable window beats a timeout landing on the same edge.
                ST_STABLE: begin
                    if (lock_s && (stable_cnt >= STABLE_LAST)) begin
                        state   <= ST_RUN;
                        attempt <= '0;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        hold_cnt <= '0;
                        if (attempt < RETRY_MAX) begin
                            attempt <= attempt + 1'b1;
                            state   <= ST_RST;
                        end else begin
                            state <= ST_FAIL;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (lock_s) begin
                            stable_cnt <= stable_cnt + 1'b1;
                        end else begin
                            stable_cnt <= '0;
                            state      <= ST_WAIT_LOCK;
                        end
                    end
                end

                ST_RUN: begin
                    attempt <= '0;
                    if (!lock_s) begin
                        state    <= ST_RST;
                        hold_cnt <= '0;
                        lost     <= 1'b1;
                    end else if (relock_req) begin
                        state    <= ST_RST;
                        hold_cnt <= '0;
                    end
                end

                ST_FAIL: begin
                    if (relock_req) begin
                        state    <= ST_RST;
                        hold_cnt <= '0;
                        attempt  <= '0;
                    end
                end

                default: begin
                    state    <= ST_RST;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
